// File: rtl/ps2_game_pkg.sv
// ps2_game_pkg
// Shared definitions for the PS/2 game controller: scan-code constants for
// the prefix bytes and tracked keys, and the prefix FSM state encoding.
// No ports.
package ps2_game_pkg;

    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;  // E0 6B, left arrow
    localparam logic [7:0] SC_RIGHT_EXT = 8'h74;  // E0 74, right arrow
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_D         = 8'h23;
    localparam logic [7:0] SC_SPACE     = 8'h29;
    localparam logic [7:0] SC_P         = 8'h4D;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_e;

    function automatic logic is_prefix(input logic [7:0] code);
        return (code == SC_BREAK) || (code == SC_EXT);
    endfunction

endpackage

// File: rtl/ps2_game_if.sv
// ps2_game_if
// Bundles the keyboard byte stream and the game control outputs.
//   scan_code  [7:0] received PS/2 byte (keyboard side drives)
//   scan_ready       one-cycle strobe qualifying scan_code
//   move_left        level, left movement requested
//   move_right       level, right movement requested
//   fire             one-cycle pulse, spawn one bullet
//   pause            level, game paused
// Modports: master = byte source / output consumer, slave = controller.
interface ps2_game_if;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       move_left;
    logic       move_right;
    logic       fire;
    logic       pause;

    modport master (
        output scan_code, scan_ready,
        input  move_left, move_right, fire, pause
    );

    modport slave (
        input  scan_code, scan_ready,
        output move_left, move_right, fire, pause
    );
endinterface

// File: rtl/ps2_prefix_fsm.sv
// ps2_prefix_fsm
// Folds the F0 (break) and E0 (extended) prefixes into a single key event.
//   clk, rst_n        clock, async active-low reset
//   scan_code/ready   incoming byte and its strobe
//   key_code          code of the completed key event
//   is_make / is_ext  make (1) or break (0); extended (E0) key
//   key_valid         strobe, combinational in the scan_ready cycle
// A pending prefix is dropped after PREFIX_TIMEOUT quiet cycles.
//
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_BRK     | F0 seen, next code is a break
// ST_EXT     | E0 seen, next code is an extended make
// ST_EXT_BRK | E0 F0 seen, next code is an extended break
module ps2_prefix_fsm
    import ps2_game_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic [7:0] key_code,
    output logic       is_make,
    output logic       is_ext,
    output logic       key_valid
);

    localparam int              TMR_W    = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PREFIX_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    prefix_state_e    state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        key_code  = scan_code;
        is_make   = 1'b0;
        is_ext    = 1'b0;
        key_valid = 1'b0;

        if (scan_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == SC_BREAK)    state_d = ST_BRK;
                    else if (scan_code == SC_EXT) state_d = ST_EXT;
                    else begin
                        key_valid = 1'b1;
                        is_make   = 1'b1;
                    end
                end
                ST_BRK: begin
                    // Stray prefixes after F0 keep the break pending.
                    if (!is_prefix(scan_code)) begin
                        key_valid = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (scan_code == SC_BREAK)    state_d = ST_EXT_BRK;
                    else if (scan_code == SC_EXT) state_d = ST_EXT;
                    else begin
                        key_valid = 1'b1;
                        is_make   = 1'b1;
                        is_ext    = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    key_valid = 1'b1;
                    is_ext    = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            // Every byte restarts the quiet-time window of a pending prefix.
            timer_d = (state_d == ST_IDLE) ? '0 : TMR_LOAD;
        end else if (state_q != ST_IDLE) begin
            if (timer_q <= TMR_ONE) begin
                state_d = ST_IDLE;
                timer_d = '0;
            end else begin
                timer_d = timer_q - TMR_ONE;
            end
        end
    end

endmodule

// File: rtl/ps2_game_ctrl.sv
// ps2_game_ctrl
// Turns PS/2 key events into game controls: movement levels, a
// rate-limited fire pulse and a pause toggle.
//   iVGA_CLK  sole clock
//   iRST_n    async active-low reset
//   bus       ps2_game_if.slave: scan_code/scan_ready in,
//             move_left/move_right/fire/pause out
module ps2_game_ctrl
    import ps2_game_pkg::*;
#(
    parameter int FIRE_COOLDOWN  = 2_500_000,
    parameter int PREFIX_TIMEOUT = 250_000
) (
    input  logic    iVGA_CLK,
    input  logic    iRST_n,
    ps2_game_if.slave bus
);

    localparam int              CD_W    = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FIRE_COOLDOWN - 1);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

    logic [7:0] key_code;
    logic       is_make;
    logic       is_ext;
    logic       key_valid;

    ps2_prefix_fsm #(
        .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
    ) u_prefix (
        .clk        (iVGA_CLK),
        .rst_n      (iRST_n),
        .scan_code  (bus.scan_code),
        .scan_ready (bus.scan_ready),
        .key_code   (key_code),
        .is_make    (is_make),
        .is_ext     (is_ext),
        .key_valid  (key_valid)
    );

    logic            left_held_q,  left_held_d;
    logic            right_held_q, right_held_d;
    logic            fire_held_q,  fire_held_d;
    logic            p_held_q,     p_held_d;
    logic            pause_q,      pause_d;
    logic            move_left_q,  move_left_d;
    logic            move_right_q, move_right_d;
    logic            fire_q,       fire_d;
    logic [CD_W-1:0] cooldown_q,   cooldown_d;

    logic hit_left, hit_right, hit_fire, hit_pause;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            left_held_q  <= 1'b0;
            right_held_q <= 1'b0;
            fire_held_q  <= 1'b0;
            p_held_q     <= 1'b0;
            pause_q      <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            fire_q       <= 1'b0;
            cooldown_q   <= '0;
        end else begin
            left_held_q  <= left_held_d;
            right_held_q <= right_held_d;
            fire_held_q  <= fire_held_d;
            p_held_q     <= p_held_d;
            pause_q      <= pause_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            fire_q       <= fire_d;
            cooldown_q   <= cooldown_d;
        end
    end

    always_comb begin
        // Extended codes only count where the key has an extended mapping.
        hit_left  = key_valid && ((is_ext && key_code == SC_LEFT_EXT) ||
                                  (!is_ext && key_code == SC_A));
        hit_right = key_valid && ((is_ext && key_code == SC_RIGHT_EXT) ||
                                  (!is_ext && key_code == SC_D));
        hit_fire  = key_valid && !is_ext && (key_code == SC_SPACE);
        hit_pause = key_valid && !is_ext && (key_code == SC_P);

        left_held_d  = hit_left  ? is_make : left_held_q;
        right_held_d = hit_right ? is_make : right_held_q;
        fire_held_d  = hit_fire  ? is_make : fire_held_q;
        p_held_d     = hit_pause ? is_make : p_held_q;

        // Typematic repeats arrive with p_held_q already set.
        pause_d = pause_q;
        if (hit_pause && is_make && !p_held_q)
            pause_d = ~pause_q;

        move_left_d  = left_held_q  & ~right_held_q & ~pause_q;
        move_right_d = right_held_q & ~left_held_q  & ~pause_q;

        cooldown_d = (cooldown_q != '0) ? cooldown_q - CD_ONE : cooldown_q;
        // Gating on pause_d keeps fire and pause from overlapping on the
        // edge that enters pause.
        fire_d = fire_held_q && (cooldown_q == '0) && !pause_d;
        if (fire_d)
            cooldown_d = CD_LOAD;
        if (pause_d)
            cooldown_d = '0;
    end

    assign bus.move_left  = move_left_q;
    assign bus.move_right = move_right_q;
    assign bus.fire       = fire_q;
    assign bus.pause      = pause_q;

endmodule

// File: tb/tb_ps2_game_ctrl.sv
module tb_ps2_game_ctrl;

    localparam int FC = 100;
    localparam int PT = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ps2_game_if bus ();

    ps2_game_ctrl #(
        .FIRE_COOLDOWN  (FC),
        .PREFIX_TIMEOUT (PT)
    ) dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .bus      (bus)
    );

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.scan_code  = b;
        bus.scan_ready = 1'b1;
        @(negedge clk);
        bus.scan_ready = 1'b0;
        bus.scan_code  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        idle(3);
        checks++;
        if (bus.move_left !== 1'b0) begin
            failures++; $display("FAIL reset_move_left got=%b exp=0", bus.move_left);
        end
        checks++;
        if (bus.move_right !== 1'b0) begin
            failures++; $display("FAIL reset_move_right got=%b exp=0", bus.move_right);
        end
        checks++;
        if (bus.fire !== 1'b0) begin
            failures++; $display("FAIL reset_fire got=%b exp=0", bus.fire);
        end
        checks++;
        if (bus.pause !== 1'b0) begin
            failures++; $display("FAIL reset_pause got=%b exp=0", bus.pause);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_ext_arrows;
        send_byte(8'hE0); send_byte(8'h6B); idle(1);
        checks++;
        if (bus.move_left !== 1'b1) begin
            failures++; $display("FAIL ext_left_make got=%b exp=1", bus.move_left);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B); idle(1);
        checks++;
        if (bus.move_left !== 1'b0) begin
            failures++; $display("FAIL ext_left_break got=%b exp=0", bus.move_left);
        end
        send_byte(8'hE0); send_byte(8'h74); idle(1);
        checks++;
        if (bus.move_right !== 1'b1) begin
            failures++; $display("FAIL ext_right_make got=%b exp=1", bus.move_right);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74); idle(1);
        checks++;
        if (bus.move_right !== 1'b0) begin
            failures++; $display("FAIL ext_right_break got=%b exp=0", bus.move_right);
        end
        // E0 1C has no extended mapping and must not move left.
        send_byte(8'hE0); send_byte(8'h1C); idle(1);
        checks++;
        if (bus.move_left !== 1'b0) begin
            failures++; $display("FAIL ext_1c_ignored got=%b exp=0", bus.move_left);
        end
    endtask

    task automatic test_both_keys;
        send_byte(8'h1C); idle(1);
        checks++;
        if (bus.move_left !== 1'b1) begin
            failures++; $display("FAIL a_make got=%b exp=1", bus.move_left);
        end
        send_byte(8'h23); idle(1);
        checks++;
        if ({bus.move_left, bus.move_right} !== 2'b00) begin
            failures++; $display("FAIL both_held got=%b%b exp=00", bus.move_left, bus.move_right);
        end
        send_byte(8'hF0); send_byte(8'h1C); idle(1);
        checks++;
        if ({bus.move_left, bus.move_right} !== 2'b01) begin
            failures++; $display("FAIL a_release got=%b%b exp=01", bus.move_left, bus.move_right);
        end
        send_byte(8'hF0); send_byte(8'h23); idle(1);
        checks++;
        if (bus.move_right !== 1'b0) begin
            failures++; $display("FAIL d_release got=%b exp=0", bus.move_right);
        end
    endtask

    task automatic test_fire;
        int n;
        int pos[4];
        n = 0;
        send_byte(8'h29);
        for (int i = 1; i <= 2 * FC + 10; i++) begin
            @(negedge clk);
            if (bus.fire === 1'b1) begin
                if (n < 4) pos[n] = i;
                n++;
            end
        end
        checks++;
        if (n !== 3) begin
            failures++; $display("FAIL fire_count got=%0d exp=3", n);
        end else begin
            checks++;
            if (pos[0] !== 1) begin
                failures++; $display("FAIL fire_first got=%0d exp=1", pos[0]);
            end
            checks++;
            if ((pos[1] - pos[0]) !== FC || (pos[2] - pos[1]) !== FC) begin
                failures++; $display("FAIL fire_spacing got=%0d,%0d exp=%0d", pos[1] - pos[0], pos[2] - pos[1], FC);
            end
        end
        send_byte(8'hF0); send_byte(8'h29);
        n = 0;
        for (int i = 0; i < FC + 50; i++) begin
            @(negedge clk);
            if (bus.fire === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            failures++; $display("FAIL fire_after_release got=%0d exp=0", n);
        end
    endtask

    task automatic test_pause;
        int n;
        send_byte(8'h4D); idle(1);
        checks++;
        if (bus.pause !== 1'b1) begin
            failures++; $display("FAIL pause_on got=%b exp=1", bus.pause);
        end
        send_byte(8'h4D); send_byte(8'h4D);
        send_byte(8'hF0); send_byte(8'h4D); idle(1);
        checks++;
        if (bus.pause !== 1'b1) begin
            failures++; $display("FAIL pause_repeat got=%b exp=1", bus.pause);
        end
        n = 0;
        send_byte(8'h1C);
        send_byte(8'h29);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.fire === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            failures++; $display("FAIL fire_while_paused got=%0d exp=0", n);
        end
        checks++;
        if (bus.move_left !== 1'b0) begin
            failures++; $display("FAIL move_while_paused got=%b exp=0", bus.move_left);
        end
        send_byte(8'hF0); send_byte(8'h29);
        send_byte(8'h4D); idle(1);
        checks++;
        if ({bus.pause, bus.move_left} !== 2'b01) begin
            failures++; $display("FAIL unpause got=pause%b,left%b exp=pause0,left1", bus.pause, bus.move_left);
        end
        send_byte(8'hF0); send_byte(8'h4D);
        send_byte(8'hF0); send_byte(8'h1C); idle(1);
    endtask

    task automatic test_timeout;
        send_byte(8'hF0);
        idle(PT + 10);
        send_byte(8'h1C); idle(1);
        checks++;
        if (bus.move_left !== 1'b1) begin
            failures++; $display("FAIL prefix_timeout got=%b exp=1", bus.move_left);
        end
        // Second F0 inside the window restarts it, so 1C is still a break.
        send_byte(8'hF0);
        idle(PT - 10);
        send_byte(8'hF0);
        idle(PT - 10);
        send_byte(8'h1C); idle(1);
        checks++;
        if (bus.move_left !== 1'b0) begin
            failures++; $display("FAIL timeout_restart got=%b exp=0", bus.move_left);
        end
    endtask

    task automatic test_reset_mid;
        send_byte(8'h1C); idle(1);
        send_byte(8'hE0);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        checks++;
        if ({bus.move_left, bus.move_right, bus.fire, bus.pause} !== 4'b0000) begin
            failures++; $display("FAIL reset_mid_outputs got=%b%b%b%b exp=0000",
                                 bus.move_left, bus.move_right, bus.fire, bus.pause);
        end
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h74); idle(2);
        checks++;
        if ({bus.move_left, bus.move_right} !== 2'b00) begin
            failures++; $display("FAIL reset_drops_e0 got=%b%b exp=00", bus.move_left, bus.move_right);
        end
        send_byte(8'hE0); send_byte(8'h74); idle(1);
        checks++;
        if (bus.move_right !== 1'b1) begin
            failures++; $display("FAIL post_reset_right got=%b exp=1", bus.move_right);
        end
    endtask

    initial begin
        bus.scan_code  = 8'h00;
        bus.scan_ready = 1'b0;
        test_reset();
        test_ext_arrows();
        test_both_keys();
        test_fire();
        test_pause();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
